// File: rtl/vga_arb_pkg.sv
// Shared types and widths for the VGA plot arbiter.
// State encoding plus default 160x120 3-bit geometry.
package vga_arb_pkg;

    localparam int X_W       = 8;
    localparam int Y_W       = 7;
    localparam int C_W       = 3;
    localparam int DEF_X_MAX = 160;
    localparam int DEF_Y_MAX = 120;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_GRANT
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr, wrapping.
// Ports: req_i (requests), ptr_i (last winner) -> gnt_o (one-hot),
// idx_o (winner index), any_o (some request present).
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    // Distance k = 1..N from ptr; ptr itself is considered last.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!any_o && req_i[i] &&
                    (i == (int'(ptr_i) + k) % N)) begin
                    any_o    = 1'b1;
                    gnt_o[i] = 1'b1;
                    idx_o    = PW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares the VGA adapter plot port among NUM_REQ burst requesters
// and runs a built-in full-screen clear engine.
// Ports: clk, reset (async high); req/pix_valid/last/pix_x/pix_y/pix_c
// per-requester lanes; clear_start pulse; grant (one-hot owner),
// busy, clear_done, oob, and registered x_out/y_out/c_out/plot.
module vga_plot_arbiter
    import vga_arb_pkg::*;
#(
    parameter int              NUM_REQ      = 3,
    parameter int              X_MAX        = DEF_X_MAX,
    parameter int              Y_MAX        = DEF_Y_MAX,
    parameter logic [C_W-1:0]  CLEAR_COLOUR = 3'b000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     pix_valid,
    input  logic [NUM_REQ-1:0]     last,
    input  logic [X_W*NUM_REQ-1:0] pix_x,
    input  logic [Y_W*NUM_REQ-1:0] pix_y,
    input  logic [C_W*NUM_REQ-1:0] pix_c,
    output logic [NUM_REQ-1:0]     grant,
    input  logic                   clear_start,
    output logic                   busy,
    output logic                   clear_done,
    output logic                   oob,
    output logic [X_W-1:0]         x_out,
    output logic [Y_W-1:0]         y_out,
    output logic [C_W-1:0]         c_out,
    output logic                   plot
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [X_W-1:0] X_LAST = X_W'(X_MAX - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_MAX - 1);
    localparam logic [PW-1:0]  PTR_RST = PW'(NUM_REQ - 1);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic                 pend_q, pend_d;
    logic [X_W-1:0]       cx_q, cx_d;
    logic [Y_W-1:0]       cy_q, cy_d;
    logic [X_W-1:0]       x_q, x_d;
    logic [Y_W-1:0]       y_q, y_d;
    logic [C_W-1:0]       c_q, c_d;
    logic                 plot_q, plot_d;
    logic                 done_q, done_d;
    logic                 oob_q, oob_d;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [PW-1:0]        arb_idx;
    logic                 arb_any;

    logic                 own_req;
    logic                 own_valid;
    logic                 own_last;
    logic [X_W-1:0]       own_x;
    logic [Y_W-1:0]       own_y;
    logic [C_W-1:0]       own_c;
    logic                 in_range;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // While granted, ptr_q holds the owner index.
    always_comb begin
        own_req   = 1'b0;
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_x     = '0;
        own_y     = '0;
        own_c     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i == int'(ptr_q)) begin
                own_req   = req[i];
                own_valid = pix_valid[i];
                own_last  = last[i];
                own_x     = pix_x[X_W*i +: X_W];
                own_y     = pix_y[Y_W*i +: Y_W];
                own_c     = pix_c[C_W*i +: C_W];
            end
        end
    end

    assign in_range = (int'(own_x) < X_MAX) && (int'(own_y) < Y_MAX);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        pend_d  = pend_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        x_d     = '0;
        y_d     = '0;
        c_d     = '0;
        plot_d  = 1'b0;
        done_d  = 1'b0;
        oob_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pend_q || clear_start) begin
                    state_d = S_CLEAR;
                    pend_d  = 1'b0;
                end else if (arb_any) begin
                    state_d = S_GRANT;
                    grant_d = arb_gnt;
                    ptr_d   = arb_idx;
                end
            end
            S_CLEAR: begin
                plot_d = 1'b1;
                x_d    = cx_q;
                y_d    = cy_q;
                c_d    = CLEAR_COLOUR;
                if (cx_q == X_LAST) begin
                    cx_d = '0;
                    if (cy_q == Y_LAST) begin
                        cy_d    = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cy_d = cy_q + 1'b1;
                    end
                end else begin
                    cx_d = cx_q + 1'b1;
                end
            end
            S_GRANT: begin
                if (clear_start) begin
                    pend_d = 1'b1;
                end
                if (own_valid) begin
                    if (in_range) begin
                        plot_d = 1'b1;
                        x_d    = own_x;
                        y_d    = own_y;
                        c_d    = own_c;
                    end else begin
                        oob_d = 1'b1;
                    end
                end
                // A last pixel ends the burst even if req already fell.
                if ((own_valid && own_last) || !own_req) begin
                    grant_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            ptr_q   <= PTR_RST;
            pend_q  <= 1'b0;
            cx_q    <= '0;
            cy_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            c_q     <= '0;
            plot_q  <= 1'b0;
            done_q  <= 1'b0;
            oob_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            pend_q  <= pend_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            x_q     <= x_d;
            y_q     <= y_d;
            c_q     <= c_d;
            plot_q  <= plot_d;
            done_q  <= done_d;
            oob_q   <= oob_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign grant      = grant_q;
    assign x_out      = x_q;
    assign y_out      = y_q;
    assign c_out      = c_q;
    assign plot       = plot_q;
    assign clear_done = done_q;
    assign oob        = oob_q;

endmodule
